// File: rtl/aibcr3_rxdeser.sv
// rtl/aibcr3_rxdeser.sv - AIB RX DDR-pair deserializer with marker hunt, lock confirm and word alignment
// Builds words from odat0/odat1 pairs, locks on a repeated marker at bit offset 0 or 1.
module aibcr3_rxdeser #(
  parameter int                WORD_W   = 10,
  parameter logic [WORD_W-1:0] MARKER   = 10'h3E0,
  parameter int                LOCK_CNT = 4
) (
  input  logic              istrbclk,
  input  logic              irstb,
  input  logic              idat0,
  input  logic              idat1,
  input  logic              ialign_en,
  output logic [WORD_W-1:0] odata,
  output logic              odata_vld,
  output logic              olocked,
  output logic              obit_off,
  output logic              oalign_err
);

  localparam int HALF = WORD_W / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2*WORD_W-1:0] hist_q, hist_d;
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d, beat_next;
  logic [3:0]          match_cnt_q, match_cnt_d, match_inc;
  logic [WORD_W-1:0]   odata_q, odata_d;
  logic                odata_vld_q, odata_vld_d;
  logic                olocked_q, olocked_d;
  logic                obit_off_q, obit_off_d;
  logic                oalign_err_q, oalign_err_d;

  logic [WORD_W-1:0]   win0, win1, win_sel;
  logic                boundary;

  // Windows are taken from the post-shift history so a word is seen in the cycle its last pair arrives.
  always_comb begin
    hist_d    = {hist_q[2*WORD_W-3:0], idat0, idat1};
    win0      = hist_d[WORD_W-1:0];
    win1      = hist_d[WORD_W:1];
    win_sel   = obit_off_q ? win1 : win0;
    boundary  = (beat_cnt_q == BW'(HALF - 1));
    beat_next = boundary ? '0 : beat_cnt_q + BW'(1);
    match_inc = match_cnt_q + 4'd1;
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    match_cnt_d  = match_cnt_q;
    odata_d      = odata_q;
    odata_vld_d  = 1'b0;
    olocked_d    = olocked_q;
    obit_off_d   = obit_off_q;
    oalign_err_d = 1'b0;

    if (!ialign_en) begin
      // Dropping enable abandons alignment but keeps the last word and offset visible.
      state_d     = S_IDLE;
      olocked_d   = 1'b0;
      match_cnt_d = '0;
      beat_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          olocked_d = 1'b0;
          state_d   = S_HUNT;
        end

        S_HUNT: begin
          beat_cnt_d = '0;
          if (win0 == MARKER) begin
            obit_off_d  = 1'b0;
            match_cnt_d = 4'd1;
            state_d     = S_CONFIRM;
          end else if (win1 == MARKER) begin
            obit_off_d  = 1'b1;
            match_cnt_d = 4'd1;
            state_d     = S_CONFIRM;
          end
        end

        S_CONFIRM: begin
          beat_cnt_d = beat_next;
          if (boundary) begin
            if (win_sel == MARKER) begin
              match_cnt_d = match_inc;
              if (match_inc >= 4'(LOCK_CNT)) begin
                state_d   = S_LOCKED;
                olocked_d = 1'b1;
              end
            end else begin
              oalign_err_d = 1'b1;
              match_cnt_d  = '0;
              state_d      = S_HUNT;
            end
          end
        end

        S_LOCKED: begin
          beat_cnt_d = beat_next;
          olocked_d  = 1'b1;
          if (boundary) begin
            odata_d     = win_sel;
            odata_vld_d = 1'b1;
          end
        end

        default: begin
          state_d     = S_IDLE;
          olocked_d   = 1'b0;
          match_cnt_d = '0;
          beat_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge istrbclk or negedge irstb) begin
    if (!irstb) begin
      state_q      <= S_IDLE;
      hist_q       <= '0;
      beat_cnt_q   <= '0;
      match_cnt_q  <= '0;
      odata_q      <= '0;
      odata_vld_q  <= 1'b0;
      olocked_q    <= 1'b0;
      obit_off_q   <= 1'b0;
      oalign_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      beat_cnt_q   <= beat_cnt_d;
      match_cnt_q  <= match_cnt_d;
      odata_q      <= odata_d;
      odata_vld_q  <= odata_vld_d;
      olocked_q    <= olocked_d;
      obit_off_q   <= obit_off_d;
      oalign_err_q <= oalign_err_d;
    end
  end

  assign odata      = odata_q;
  assign odata_vld  = odata_vld_q;
  assign olocked    = olocked_q;
  assign obit_off   = obit_off_q;
  assign oalign_err = oalign_err_q;

endmodule

// File: tb/tb_aibcr3_rxdeser.sv
// tb/tb_aibcr3_rxdeser.sv - bench for aibcr3_rxdeser: word table, corner sequences, random stream vs bit-level model
// The model locates words by bit distance from the last aligned marker rather than by a pair counter.
module tb_aibcr3_rxdeser;
  localparam int         W  = 10;
  localparam logic [9:0] MK = 10'h3E0;
  localparam int         LC = 4;

  logic         istrbclk = 1'b0;
  logic         irstb = 1'b0;
  logic         idat0 = 1'b0;
  logic         idat1 = 1'b0;
  logic         ialign_en = 1'b0;
  logic [W-1:0] odata;
  logic         odata_vld, olocked, obit_off, oalign_err;

  aibcr3_rxdeser #(.WORD_W(W), .MARKER(MK), .LOCK_CNT(LC)) dut (
    .istrbclk  (istrbclk),
    .irstb     (irstb),
    .idat0     (idat0),
    .idat1     (idat1),
    .ialign_en (ialign_en),
    .odata     (odata),
    .odata_vld (odata_vld),
    .olocked   (olocked),
    .obit_off  (obit_off),
    .oalign_err(oalign_err)
  );

  always #5 istrbclk = ~istrbclk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc_n  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: full received bit stream plus bit index of the last aligned word end.
  bit           sb[$];
  int           base;
  int           m_mode;
  int           m_end, m_matches;
  logic         m_locked, m_vld, m_err, m_off;
  logic [W-1:0] m_data;

  function automatic logic [W-1:0] word_at(input int last);
    logic [W-1:0] w;
    int idx;
    w = '0;
    for (int i = 0; i < W; i++) begin
      idx = last - W + 1 + i;
      w = {w[W-2:0], (idx >= base) ? sb[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic model_reset();
    base = sb.size();
    m_mode = 0; m_end = 0; m_matches = 0;
    m_locked = 0; m_vld = 0; m_err = 0; m_off = 0; m_data = '0;
  endtask

  task automatic model_step(input logic d0, input logic d1, input logic en);
    int last, ce;
    sb.push_back(d0);
    sb.push_back(d1);
    last = sb.size() - 1;
    m_vld = 0;
    m_err = 0;
    if (!en) begin
      m_mode = 0; m_locked = 0; m_matches = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (word_at(last) == MK) begin
            m_off = 0; m_end = last; m_matches = 1; m_mode = 2;
          end else if (word_at(last - 1) == MK) begin
            m_off = 1; m_end = last - 1; m_matches = 1; m_mode = 2;
          end
        end
        2: begin
          ce = last - int'(m_off);
          if (ce - m_end == W) begin
            m_end = ce;
            if (word_at(ce) == MK) begin
              m_matches++;
              if (m_matches == LC) begin m_mode = 3; m_locked = 1; end
            end else begin
              m_err = 1; m_matches = 0; m_mode = 1;
            end
          end
        end
        default: begin
          ce = last - int'(m_off);
          if (ce - m_end == W) begin
            m_end = ce; m_data = word_at(ce); m_vld = 1;
          end
        end
      endcase
    end
  endtask

  logic [W-1:0] vq[$];
  int           vt[$];
  bit           bq[$];

  task automatic cyc(input logic d0, input logic d1, input logic en);
    @(negedge istrbclk);
    idat0 = d0; idat1 = d1; ialign_en = en;
    @(posedge istrbclk);
    model_step(d0, d1, en);
    cyc_n++;
    #1;
    check($sformatf("cycle%0d_model", cyc_n),
          {olocked, odata_vld, oalign_err, obit_off, odata},
          {m_locked, m_vld, m_err, m_off, m_data});
    if (odata_vld) begin vq.push_back(odata); vt.push_back(cyc_n); end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) bq.push_back(w[i]);
  endtask

  task automatic flush(input logic en);
    logic a, b;
    while (bq.size() >= 2) begin
      a = bq.pop_front();
      b = bq.pop_front();
      cyc(a, b, en);
    end
  endtask

  task automatic do_reset();
    @(negedge istrbclk);
    irstb = 0; idat0 = 0; idat1 = 0; ialign_en = 0;
    bq.delete(); vq.delete(); vt.delete();
    @(posedge istrbclk);
    #2;
    irstb = 1;
    model_reset();
  endtask

  typedef struct packed {
    logic         rst;
    logic [W-1:0] word;
    logic         lk;
    logic         vld;
    logic         err;
    logic [W-1:0] data;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl = '{
      '{1'b1, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b1, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h155, 1'b1, 1'b1, 1'b0, 10'h155},
      '{1'b0, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h2AA},
      '{1'b0, 10'h3E0, 1'b1, 1'b1, 1'b0, 10'h3E0},
      '{1'b1, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E1, 1'b0, 1'b0, 1'b1, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b0, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h3E0, 1'b1, 1'b0, 1'b0, 10'h000},
      '{1'b0, 10'h155, 1'b1, 1'b1, 1'b0, 10'h155}
    };

    #2;
    check("reset_outputs", {olocked, odata_vld, oalign_err, obit_off, odata}, 32'h0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      push_word(tbl[i].word);
      flush(1'b1);
      check($sformatf("tbl%0d_locked", i), olocked, tbl[i].lk);
      check($sformatf("tbl%0d_vld", i), odata_vld, tbl[i].vld);
      check($sformatf("tbl%0d_err", i), oalign_err, tbl[i].err);
      check($sformatf("tbl%0d_data", i), odata, tbl[i].data);
      check($sformatf("tbl%0d_off", i), obit_off, 1'b0);
    end

    // Odd offset: one leading bit shifts every word by one position.
    do_reset();
    bq.push_back(1'b0);
    for (int i = 0; i < 4; i++) push_word(MK);
    push_word(10'h155);
    push_word(10'h2AA);
    bq.push_back(1'b0);
    flush(1'b1);
    check("odd_off", obit_off, 1'b1);
    check("odd_locked", olocked, 1'b1);
    check("odd_vld_count", vq.size(), 2);
    if (vq.size() == 2) begin
      check("odd_word0", vq[0], 10'h155);
      check("odd_word1", vq[1], 10'h2AA);
      check("odd_spacing", vt[1] - vt[0], 5);
    end

    // Enable drop while locked, then relock.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(MK);
    push_word(10'h155);
    push_word(10'h2AA);
    flush(1'b1);
    check("pre_drop_locked", olocked, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("drop_locked", olocked, 1'b0);
    check("drop_vld", odata_vld, 1'b0);
    check("drop_hold_data", odata, 10'h2AA);
    for (int i = 0; i < 3; i++) push_word(MK);
    flush(1'b1);
    check("relock_not_yet", olocked, 1'b0);
    push_word(MK);
    flush(1'b1);
    check("relock", olocked, 1'b1);

    // Asynchronous reset mid-word while locked.
    push_word(10'h2AA);
    cyc(bq.pop_front(), bq.pop_front(), 1'b1);
    cyc(bq.pop_front(), bq.pop_front(), 1'b1);
    @(posedge istrbclk);
    #3;
    irstb = 0;
    #1;
    check("async_rst_outputs", {olocked, odata_vld, oalign_err, obit_off, odata}, 32'h0);
    bq.delete(); vq.delete(); vt.delete();
    idat0 = 0; idat1 = 0;
    @(posedge istrbclk);
    #2;
    irstb = 1;
    model_reset();
    for (int i = 0; i < 6; i++) push_word(10'h155);
    flush(1'b1);
    check("post_rst_no_vld", vq.size(), 0);
    for (int i = 0; i < 4; i++) push_word(MK);
    flush(1'b1);
    check("post_rst_locked", olocked, 1'b1);

    // Continuous marker stream aligned at offset 0.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(MK);
    flush(1'b1);
    check("allmk_off", obit_off, 1'b0);
    check("allmk_locked", olocked, 1'b1);

    // Random stream: marker bursts, corrupted markers, bit slips, enable drops.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2) begin
        for (int k = 0; k < int'($urandom_range(3, 6)); k++) push_word(MK);
      end else if (r == 3) begin
        push_word(MK ^ (10'h1 << $urandom_range(0, W - 1)));
      end else if (r == 4) begin
        bq.push_back(1'($urandom));
      end else begin
        push_word(10'($urandom));
      end
      flush(1'b1);
      if ($urandom_range(0, 30) == 0) cyc(1'($urandom), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
